cdda_serial_tx: RTL and testbench



---
 rtl/cdda_pkg.sv | 18 +
 rtl/cdda_sample_fifo.sv | 55 +++++
 rtl/cdda_serial_tx.sv | 176 +++++++++++++++++
 tb/tb_cdda_serial_tx.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cdda_pkg.sv
// Shared constants and types for the Dreamcast CDDA serial transmitter.
package cdda_pkg;

   // Frame geometry: 64 SCK bits per stereo frame, 32 per channel slot,
   // 16 data bits right-justified at the end of each slot.
   localparam int unsigned FRAME_BITS = 64;
   localparam int unsigned SLOT_BITS  = 32;
   localparam int unsigned DATA_BITS  = 16;

   // LRCK level during the left-channel slot.
   localparam logic LRCK_LEFT = 1'b1;

   typedef struct packed {
      logic [DATA_BITS-1:0] left;
      logic [DATA_BITS-1:0] right;
   } sample_pair_t;

endpackage

// File: rtl/cdda_sample_fifo.sv
// Synchronous sample-pair FIFO for the CDDA transmitter (CDCLK domain only).
// Only instantiated when CDDA_TX_FIFO_EN is defined. A push against a full
// FIFO is accepted when a pop happens in the same cycle.
module cdda_sample_fifo
   import cdda_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic         i_gclk,
   input  logic         i_grst_n,
   input  logic         i_push,
   input  sample_pair_t i_data,
   input  logic         i_pop,
   output sample_pair_t o_data,
   output logic         o_full,
   output logic         o_empty
);

   localparam int unsigned AW = (DEPTH > 2) ? $clog2(DEPTH) : 1;

   sample_pair_t r_mem [DEPTH];
   logic [AW:0]  r_wr;
   logic [AW:0]  r_rd;
   logic         w_full;
   logic         w_empty;
   logic         w_wr_en;
   logic         w_rd_en;

   // Extra pointer MSB distinguishes full from empty when indices match.
   assign w_full  = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
   assign w_empty = (r_wr == r_rd);
   assign w_rd_en = i_pop && !w_empty;
   assign w_wr_en = i_push && (!w_full || w_rd_en);

   // Storage array; no reset needed, pointers guard validity.
   always_ff @(posedge i_gclk) begin
      if (w_wr_en) r_mem[r_wr[AW-1:0]] <= i_data;
   end

   // Read/write pointers.
   always_ff @(posedge i_gclk or negedge i_grst_n) begin
      if (!i_grst_n) begin
         r_wr <= '0;
         r_rd <= '0;
      end else begin
         if (w_wr_en) r_wr <= r_wr + (AW+1)'(1);
         if (w_rd_en) r_rd <= r_rd + (AW+1)'(1);
      end
   end

   assign o_data  = r_mem[r_rd[AW-1:0]];
   assign o_full  = w_full;
   assign o_empty = w_empty;

endmodule

// File: rtl/cdda_serial_tx.sv
// CDDA serializer toward the Dreamcast G1 audio receiver. Runs on CDCLK
// (384*fs); produces SCK = CDCLK/SCK_DIV, 64-bit frames with LRCK high for
// the left slot and 16-bit data right-justified, MSB first. Outputs change
// on SCK falling edges only. Optional macro CDDA_TX_FIFO_EN replaces the
// single holding register with a FIFO_DEPTH-entry FIFO.
module cdda_serial_tx
   import cdda_pkg::*;
#(
   parameter int unsigned SCK_DIV    = 6,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic        i_gclk,
   input  logic        i_grst_n,
   input  logic        i_tx_en,
   input  logic        i_emph_in,
   input  logic        i_s_valid,
   output logic        o_s_ready,
   input  logic [15:0] i_s_left,
   input  logic [15:0] i_s_right,
   output logic        o_underrun,
   input  logic        i_clr_underrun,
   output logic        o_dc_sck,
   output logic        o_dc_sdat,
   output logic        o_dc_lrck,
   output logic        o_dc_emph
);

   localparam int unsigned DW       = (SCK_DIV > 2) ? $clog2(SCK_DIV) : 1;
   localparam logic [DW-1:0] DIV_LAST = DW'(SCK_DIV - 1);
   // Divider value one cycle before it reaches SCK_DIV/2.
   localparam logic [DW-1:0] DIV_PREH = DW'(SCK_DIV/2 - 1);
   localparam logic [5:0] BIT_LAST = 6'(FRAME_BITS - 1);
   localparam logic [4:0] P_DATA   = 5'(SLOT_BITS - DATA_BITS);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   if ((SCK_DIV < 2) || (SCK_DIV % 2 != 0) || (FIFO_DEPTH < 2)) begin : g_bad_param
      $error("cdda_serial_tx: SCK_DIV must be even >= 2, FIFO_DEPTH >= 2");
   end

   logic [0:0]   r_state;
   logic [DW-1:0] r_div;
   logic [5:0]   r_bit;
   logic [31:0]  r_shift;
   logic         r_sck;
   logic         r_sdat;
   logic         r_lrck;
   logic         r_emph;
   logic         r_underrun;

   logic         w_run;
   logic         w_rise;
   logic         w_fall;
   logic         w_frame_end;
   logic         w_load;
   logic         w_park;
   logic [5:0]   w_bit_nxt;
   logic         w_push;
   logic         w_pop;
   logic         w_ready;
   logic         w_buf_empty;
   sample_pair_t w_buf_data;
   sample_pair_t w_in_pair;

   // Enabling takes effect in the same cycle so a start from reset puts the
   // first falling edge (frame load) at cycle SCK_DIV/2 + SCK_DIV.
   assign w_run       = (r_state == ST_RUN) || i_tx_en;
   assign w_rise      = w_run && (r_div == DIV_LAST);
   // The first half-way point after (re)start is skipped because SCK has
   // not risen yet.
   assign w_fall      = w_run && r_sck && (r_div == DIV_PREH);
   assign w_frame_end = w_fall && (r_bit == BIT_LAST);
   assign w_load      = w_frame_end && i_tx_en;
   assign w_park      = w_frame_end && !i_tx_en;
   assign w_bit_nxt   = r_bit + 6'd1;
   assign w_pop       = w_load && !w_buf_empty;
   assign w_push      = i_s_valid && w_ready;
   assign w_in_pair   = '{left: i_s_left, right: i_s_right};

   // Divider, SCK generation, bit counter and serial output registers.
   always_ff @(posedge i_gclk or negedge i_grst_n) begin
      if (!i_grst_n) begin
         r_state <= ST_IDLE;
         r_div   <= '0;
         r_bit   <= BIT_LAST;
         r_shift <= '0;
         r_sck   <= 1'b0;
         r_sdat  <= 1'b0;
         r_lrck  <= 1'b0;
         r_emph  <= 1'b0;
      end else if (w_park) begin
         // Frame finished with TX disabled: back to the reset picture.
         r_state <= ST_IDLE;
         r_div   <= '0;
         r_bit   <= BIT_LAST;
         r_shift <= '0;
         r_sck   <= 1'b0;
         r_sdat  <= 1'b0;
         r_lrck  <= 1'b0;
         r_emph  <= 1'b0;
      end else if (w_run) begin
         r_state <= ST_RUN;
         r_div   <= (r_div == DIV_LAST) ? '0 : r_div + DW'(1);
         if (w_rise) r_sck <= 1'b1;
         if (w_fall) begin
            r_sck  <= 1'b0;
            r_bit  <= w_bit_nxt;
            r_lrck <= w_bit_nxt[5] ? ~LRCK_LEFT : LRCK_LEFT;
            if (w_load) begin
               // Empty buffer: this frame shifts zeros.
               r_shift <= w_buf_empty ? '0 : w_buf_data;
               r_sdat  <= 1'b0;
               r_emph  <= i_emph_in;
            end else if (w_bit_nxt[4:0] >= P_DATA) begin
               r_sdat  <= r_shift[31];
               r_shift <= {r_shift[30:0], 1'b0};
            end else begin
               r_sdat  <= 1'b0;
            end
         end
      end
   end

   // Sticky underrun flag; a new underrun beats a simultaneous clear.
   always_ff @(posedge i_gclk or negedge i_grst_n) begin
      if (!i_grst_n)                 r_underrun <= 1'b0;
      else if (w_load && w_buf_empty) r_underrun <= 1'b1;
      else if (i_clr_underrun)        r_underrun <= 1'b0;
   end

`ifdef CDDA_TX_FIFO_EN
   logic w_fifo_full;

   cdda_sample_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .i_gclk   (i_gclk),
      .i_grst_n (i_grst_n),
      .i_push   (w_push),
      .i_data   (w_in_pair),
      .i_pop    (w_pop),
      .o_data   (w_buf_data),
      .o_full   (w_fifo_full),
      .o_empty  (w_buf_empty)
   );

   assign w_ready = !w_fifo_full;
`else
   sample_pair_t r_hold;
   logic         r_full;

   // Single holding register; a same-cycle push and pop leaves it full.
   always_ff @(posedge i_gclk or negedge i_grst_n) begin
      if (!i_grst_n) begin
         r_hold <= '0;
         r_full <= 1'b0;
      end else begin
         if (w_push) r_hold <= w_in_pair;
         r_full <= w_push || (r_full && !w_pop);
      end
   end

   assign w_ready     = !r_full;
   assign w_buf_empty = !r_full;
   assign w_buf_data  = r_hold;
`endif

   assign o_s_ready  = w_ready;
   assign o_underrun = r_underrun;
   assign o_dc_sck   = r_sck;
   assign o_dc_sdat  = r_sdat;
   assign o_dc_lrck  = r_lrck;
   assign o_dc_emph  = r_emph;

endmodule

// File: tb/tb_cdda_serial_tx.sv
// Bench for cdda_serial_tx: random sample stream against a frame-level
// receiver model (decodes SCK/LRCK/SDAT) plus a sample queue scoreboard.
module tb_cdda_serial_tx;

   localparam int SCK_DIV   = 6;
   localparam int FRAME_CYC = 64 * SCK_DIV;
   localparam int FIRST_FALL = SCK_DIV/2 + SCK_DIV;
`ifdef CDDA_TX_FIFO_EN
   localparam int BUF_DEPTH = 4;
`else
   localparam int BUF_DEPTH = 1;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic tx_en = 1'b0;
   logic emph_in = 1'b0;
   logic s_valid = 1'b0;
   logic clr = 1'b0;
   logic [15:0] s_left = '0;
   logic [15:0] s_right = '0;
   logic o_s_ready, o_underrun, o_dc_sck, o_dc_sdat, o_dc_lrck, o_dc_emph;

   cdda_serial_tx #(.SCK_DIV(SCK_DIV), .FIFO_DEPTH(4)) dut (
      .i_gclk         (clk),
      .i_grst_n       (rst_n),
      .i_tx_en        (tx_en),
      .i_emph_in      (emph_in),
      .i_s_valid      (s_valid),
      .o_s_ready      (o_s_ready),
      .i_s_left       (s_left),
      .i_s_right      (s_right),
      .o_underrun     (o_underrun),
      .i_clr_underrun (clr),
      .o_dc_sck       (o_dc_sck),
      .o_dc_sdat      (o_dc_sdat),
      .o_dc_lrck      (o_dc_lrck),
      .o_dc_emph      (o_dc_emph)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // Model state
   logic [31:0] q[$];      // accepted, not yet framed sample pairs
   logic [31:0] exp_f[$];  // pair expected in each loaded frame
   logic m_under = 1'b0;
   logic m_emph = 1'b0;
   logic prev_lr = 1'b0;
   int cyc = 0, load_cnt = 0, load_cyc = 0, last_load = 0;
   bit have_prev = 0;
   bit mon_blk = 0;
   int blk = 0, max_blk = 0;

   // What happened at the last rising CDCLK edge (pre-edge values).
   bit pe_push, pe_clr, pe_emph;
   logic [31:0] pe_pair;
   always @(posedge clk) begin
      pe_push = s_valid && o_s_ready;
      pe_pair = {s_left, s_right};
      pe_clr  = clr;
      pe_emph = emph_in;
   end

   // Scoreboard: a frame starts where LRCK rises; it takes the oldest
   // queued pair, or zeros plus an underrun if nothing is queued.
   always @(negedge clk) begin
      if (rst_n) begin
         cyc++;
         if (o_dc_lrck && !prev_lr) begin
            load_cnt++;
            load_cyc = cyc;
            if (have_prev) chk("frame_len", 64'(cyc - last_load), 64'(FRAME_CYC));
            have_prev = 1;
            last_load = cyc;
            m_emph = pe_emph;
            if (q.size() > 0) exp_f.push_back(q.pop_front());
            else begin
               exp_f.push_back(32'h0);
               m_under = 1'b1;
            end
         end else if (pe_clr) begin
            m_under = 1'b0;
         end
         prev_lr = o_dc_lrck;
         if (pe_push) q.push_back(pe_pair);
         chk("s_ready", 64'(o_s_ready), 64'(q.size() < BUF_DEPTH));
         chk("underrun", 64'(o_underrun), 64'(m_under));
         chk("emph", 64'(o_dc_emph), 64'(m_emph));
         if (mon_blk) begin
            if (s_valid && !o_s_ready) blk++; else blk = 0;
            if (blk > max_blk) max_blk = blk;
         end
      end
   end

   // Receiver: samples on SCK rising edges, frame begins when LRCK goes high.
   int rx_idx = -1;
   logic rx_prev = 1'b0;
   logic [63:0] rx_dat, rx_lr;
   int frames_rx = 0;
   always @(posedge o_dc_sck) begin
      if (o_dc_lrck && !rx_prev) rx_idx = 0;
      rx_prev = o_dc_lrck;
      if (rx_idx >= 0) begin
         rx_dat[63-rx_idx] = o_dc_sdat;
         rx_lr[63-rx_idx]  = o_dc_lrck;
         rx_idx++;
         if (rx_idx == 64) begin
            rx_idx = -1;
            frames_rx++;
            if (exp_f.size() == 0) chk("frame_expected", 64'(0), 64'(1));
            else begin
               logic [31:0] p;
               p = exp_f.pop_front();
               chk("frame_data", rx_dat, {16'h0, p[31:16], 16'h0, p[15:0]});
            end
            chk("frame_lrck", rx_lr, {32'hFFFF_FFFF, 32'h0});
         end
      end
   end

   // Background source: incrementing left word, random right word,
   // random valid gaps, optional random EMPH toggling.
   bit drv_en = 0, drv_emph = 0;
   logic [15:0] cnt = 16'h0;
   always @(negedge clk) begin
      if (drv_en) begin
         #1;
         if (!s_valid || pe_push) begin
            cnt++;
            s_left  = cnt;
            s_right = 16'($urandom);
            s_valid = ($urandom_range(0, 3) != 0);
         end
         if (drv_emph && $urandom_range(0, 149) == 0) emph_in = ~emph_in;
      end
   end

   task automatic do_reset();
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_sck", 64'(o_dc_sck), 64'(0));
      chk("rst_sdat", 64'(o_dc_sdat), 64'(0));
      chk("rst_lrck", 64'(o_dc_lrck), 64'(0));
      chk("rst_emph", 64'(o_dc_emph), 64'(0));
      chk("rst_underrun", 64'(o_underrun), 64'(0));
      chk("rst_ready", 64'(o_s_ready), 64'(1));
      q.delete(); exp_f.delete();
      m_under = 0; m_emph = 0; prev_lr = 0; have_prev = 0; cyc = 0;
      rx_idx = -1; rx_prev = 0;
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b1;
   endtask

   task automatic wait_load(input int bound);
      int s, n;
      s = load_cnt;
      n = 0;
      while (load_cnt == s && n < bound) begin
         @(negedge clk); #1; n++;
      end
      if (load_cnt == s) chk("load_timeout", 64'(0), 64'(1));
   endtask

   initial begin
      #1_500_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int fr0, ld0, hi, lr, sd, st;
      // Reset with TX enabled, one pair pushed, then starve.
      tx_en = 1'b1;
      do_reset();
      s_valid = 1'b1; s_left = 16'h8001; s_right = 16'h00FF;
      @(negedge clk); #1 s_valid = 1'b0;
      wait_load(2*FRAME_CYC);
      chk("first_load_cyc", 64'(load_cyc), 64'(FIRST_FALL));
      wait_load(2*FRAME_CYC);
      chk("underrun_f1", 64'(o_underrun), 64'(1));
      chk("frames_rx_f0", 64'(frames_rx), 64'(1));

      // Clear, then a clear landing on the next underrun load: set wins.
      wait_load(2*FRAME_CYC);
      clr = 1'b1; @(negedge clk); #1 clr = 1'b0;
      chk("underrun_clr", 64'(o_underrun), 64'(0));
      repeat (FRAME_CYC-2) @(negedge clk);
      #1 clr = 1'b1; @(negedge clk); #1 clr = 1'b0;
      chk("underrun_setwins", 64'(o_underrun), 64'(1));

      // Continuous random stream for 100 frames with EMPH toggling.
      wait_load(2*FRAME_CYC);
      clr = 1'b1; drv_en = 1; drv_emph = 1; mon_blk = 1;
      @(negedge clk); #1 clr = 1'b0;
      fr0 = frames_rx;
      repeat (100) wait_load(2*FRAME_CYC);
      mon_blk = 0;
      chk("stream_underrun", 64'(o_underrun), 64'(0));
      chk("stream_block", 64'(max_blk <= FRAME_CYC), 64'(1));
      chk("stream_frames", 64'(frames_rx - fr0), 64'(100));

      // Drop TX_EN at b=20: frame completes, then outputs park.
      drv_emph = 0; emph_in = 1'b0;
      wait_load(2*FRAME_CYC);
      repeat (20*SCK_DIV + 2) @(negedge clk);
      #1 tx_en = 1'b0;
      fr0 = frames_rx; ld0 = load_cnt;
      repeat (FRAME_CYC) @(negedge clk);
      hi = 0; lr = 0; sd = 0;
      repeat (FRAME_CYC) begin
         @(negedge clk); #1;
         hi += int'(o_dc_sck); lr += int'(o_dc_lrck); sd += int'(o_dc_sdat);
      end
      chk("idle_sck", 64'(hi), 64'(0));
      chk("idle_lrck", 64'(lr), 64'(0));
      chk("idle_sdat", 64'(sd), 64'(0));
      chk("idle_frames", 64'(frames_rx - fr0), 64'(1));
      chk("idle_loads", 64'(load_cnt - ld0), 64'(0));
      have_prev = 0;
      @(negedge clk); #1 tx_en = 1'b1; st = cyc;
      wait_load(2*FRAME_CYC);
      chk("restart_cyc", 64'(load_cyc - st), 64'(FIRST_FALL));
      wait_load(2*FRAME_CYC);

      // Reset in the middle of a frame.
      wait_load(2*FRAME_CYC);
      repeat (200) @(negedge clk);
      do_reset();
      fr0 = frames_rx;
      repeat (3) wait_load(2*FRAME_CYC);
      chk("rst_frames", 64'(frames_rx - fr0), 64'(2));

`ifdef CDDA_TX_FIFO_EN
      // Fill the FIFO while parked, then drain in order.
      drv_en = 0;
      @(negedge clk); #2 s_valid = 1'b0;
      repeat (5) wait_load(2*FRAME_CYC);
      #1 tx_en = 1'b0;
      repeat (2*FRAME_CYC) @(negedge clk);
      have_prev = 0;
      for (int i = 0; i < 4; i++) begin
         #1 s_valid = 1'b1; s_left = 16'hA000 + 16'(i); s_right = 16'($urandom);
         @(negedge clk);
      end
      #1 s_valid = 1'b0;
      chk("fifo_full_ready", 64'(o_s_ready), 64'(0));
      fr0 = frames_rx;
      tx_en = 1'b1;
      repeat (5) wait_load(2*FRAME_CYC);
      chk("fifo_frames", 64'(frames_rx - fr0), 64'(4));
`endif

      drv_en = 0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
